axi4_mem_responder: RTL

- AXI4 full-protocol slave that answers the burst write/read traffic issued by the team's DDR read/write master.
- Backs the traffic with an internal word-addressed memory.
- Used as a synthesizable stand-in for the PS DDR port in block-level simulation and in loopback builds.
- Write and read channels run as independent state machines, so one write burst and one read burst can be in flight at the same time.

---
 rtl/axi4_mem_responder.sv | 322 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder
//   AXI4 slave backed by an internal word-addressed memory. It serves the
//   burst traffic of the DDR read/write master. The write and read channels
//   run as independent FSMs, so one write burst and one read burst can be in
//   flight at the same time.
// Ports:
//   ACLK, ARESET            clock (rising edge), asynchronous active-high reset
//   S_AXI_AW*/W*/B*         write address, write data and write response channels
//   S_AXI_AR*/R*            read address and read data channels
// Only 32-bit beats (SIZE = 3'b010) with INCR or FIXED bursts are serviced.
// WRAP bursts, reserved bursts and other sizes are answered with SLVERR.
// A beat whose address falls outside the memory window is also answered
// with SLVERR; such a write beat is dropped and such a read beat returns 0.
module axi4_mem_responder #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_MEM_DEPTH        = 1024,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h40000000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int unsigned IDX_W = (C_MEM_DEPTH > 1) ? $clog2(C_MEM_DEPTH) : 1;
  localparam int unsigned NB    = C_S_AXI_DATA_WIDTH / 8;

  typedef logic [C_S_AXI_ADDR_WIDTH-1:0] addr_t;
  typedef logic [C_S_AXI_ID_WIDTH-1:0]   id_t;
  typedef logic [C_S_AXI_DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return !(burst == 2'b00 || burst == 2'b01) || (size != 3'b010);
  endfunction

  function automatic logic addr_oob(input addr_t a);
    return (a < C_BASE_ADDR) || (((a - C_BASE_ADDR) >> 2) >= addr_t'(C_MEM_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input addr_t a);
    return IDX_W'((a - C_BASE_ADDR) >> 2);
  endfunction

  function automatic addr_t addr_next(input addr_t a, input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + addr_t'(4);
  endfunction

  data_t mem [C_MEM_DEPTH];

  // Write channel state
  wstate_e    wstate_q, wstate_d;
  logic       awready_q, awready_d;
  logic       wready_q, wready_d;
  logic       bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;
  id_t        bid_q, bid_d;
  id_t        wid_q, wid_d;
  addr_t      waddr_q, waddr_d;
  logic [7:0] wlen_q, wlen_d;
  logic [1:0] wburst_q, wburst_d;
  logic       wbad_q, wbad_d;
  logic       werr_q, werr_d;
  logic [8:0] wbeat_q, wbeat_d;

  logic             w_beat_err, w_last, w_err_n;
  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;

  // Read channel state
  rstate_e    rstate_q, rstate_d;
  logic       arready_q, arready_d;
  logic       rvalid_q, rvalid_d;
  logic       rlast_q, rlast_d;
  logic [1:0] rresp_q, rresp_d;
  data_t      rdata_q, rdata_d;
  id_t        rid_q, rid_d;
  addr_t      raddr_q, raddr_d;
  logic [7:0] rlen_q, rlen_d;
  logic [1:0] rburst_q, rburst_d;
  logic       rbad_q, rbad_d;
  logic [8:0] rbeat_q, rbeat_d;

  addr_t r_sel_addr;
  logic  r_sel_err;
  data_t r_sel_data;

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wburst_d  = wburst_q;
    wbad_d    = wbad_q;
    werr_d    = werr_q;
    wbeat_d   = wbeat_q;
    mem_we    = 1'b0;
    mem_widx  = addr_idx(waddr_q);

    w_beat_err = wbad_q || addr_oob(waddr_q);
    w_last     = (wbeat_q == {1'b0, wlen_q});
    // WLAST must appear exactly on beat AWLEN; any mismatch poisons the response
    w_err_n    = werr_q || w_beat_err || (S_AXI_WLAST != w_last);

    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (S_AXI_AWVALID && awready_q) begin
          wid_d     = S_AXI_AWID;
          waddr_d   = S_AXI_AWADDR;
          wlen_d    = S_AXI_AWLEN;
          wburst_d  = S_AXI_AWBURST;
          wbad_d    = burst_bad(S_AXI_AWBURST, S_AXI_AWSIZE);
          werr_d    = 1'b0;
          wbeat_d   = '0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wstate_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID && wready_q) begin
          mem_we = !w_beat_err;
          werr_d = w_err_n;
          if (w_last) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = wid_q;
            bresp_d  = w_err_n ? 2'b10 : 2'b00;
            wstate_d = W_RESP;
          end else begin
            wbeat_d = wbeat_q + 9'd1;
            waddr_d = addr_next(waddr_q, wburst_q);
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // The beat to present next is beat 0 of the incoming AR request while idle,
  // otherwise the beat following the one currently on the bus.
  always_comb begin
    r_sel_addr = (rstate_q == R_IDLE) ? S_AXI_ARADDR : addr_next(raddr_q, rburst_q);
    r_sel_err  = ((rstate_q == R_IDLE) ? burst_bad(S_AXI_ARBURST, S_AXI_ARSIZE) : rbad_q)
                 || addr_oob(r_sel_addr);
    r_sel_data = mem[addr_idx(r_sel_addr)];
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rburst_d  = rburst_q;
    rbad_d    = rbad_q;
    rbeat_d   = rbeat_q;

    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (S_AXI_ARVALID && arready_q) begin
          rid_d     = S_AXI_ARID;
          raddr_d   = S_AXI_ARADDR;
          rlen_d    = S_AXI_ARLEN;
          rburst_d  = S_AXI_ARBURST;
          rbad_d    = burst_bad(S_AXI_ARBURST, S_AXI_ARSIZE);
          rbeat_d   = '0;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = r_sel_err ? '0 : r_sel_data;
          rresp_d   = r_sel_err ? 2'b10 : 2'b00;
          rlast_d   = (S_AXI_ARLEN == 8'd0);
          rstate_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && S_AXI_RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            rstate_d  = R_IDLE;
          end else begin
            raddr_d = r_sel_addr;
            rbeat_d = rbeat_q + 9'd1;
            rdata_d = r_sel_err ? '0 : r_sel_data;
            rresp_d = r_sel_err ? 2'b10 : 2'b00;
            rlast_d = ((rbeat_q + 9'd1) == {1'b0, rlen_q});
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Memory has no reset; contents survive ARESET.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (S_AXI_WSTRB[b]) mem[mem_widx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      bid_q     <= '0;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wburst_q  <= '0;
      wbad_q    <= 1'b0;
      werr_q    <= 1'b0;
      wbeat_q   <= '0;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rburst_q  <= '0;
      rbad_q    <= 1'b0;
      rbeat_q   <= '0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      wbad_q    <= wbad_d;
      werr_q    <= werr_d;
      wbeat_q   <= wbeat_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      rbad_q    <= rbad_d;
      rbeat_q   <= rbeat_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RID     = rid_q;

endmodule
